// File: rtl/montre_de1_sysid_pkg.sv
// rtl/montre_de1_sysid_pkg.sv - shared types and constants for the system-ID checker
package montre_de1_sysid_pkg;

    localparam int          CNT_W      = 16;
    localparam logic [31:0] DEFAULT_ID = 32'd0;
    localparam logic [31:0] DEFAULT_TS = 32'd1684023273;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/montre_de1_avm_read_ctl.sv
// rtl/montre_de1_avm_read_ctl.sv - single Avalon-MM read handshake with per-transaction timeout
module montre_de1_avm_read_ctl
    import montre_de1_sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_phase,
    input  logic        wait_phase,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    input  logic [31:0] expected,
    output logic        read,
    output logic        accept,
    output logic        capture,
    output logic        match,
    output logic        expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign read      = req_phase;
    assign accept    = req_phase & ~waitrequest;
    assign capture   = wait_phase & readdatavalid;
    assign match     = (readdata == expected);
    assign count_inc = count + CNT_W'(1);

    // A completing handshake wins over expiry in the same cycle.
    assign expired = (req_phase | wait_phase) & ~accept & ~capture & (count_inc == LIMIT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!(req_phase || wait_phase) || accept || capture || expired) begin
            count <= '0;
        end else begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/montre_de1_sysid_checker.sv
// rtl/montre_de1_sysid_checker.sv - reads system ID and timestamp words and compares them
module montre_de1_sysid_checker
    import montre_de1_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t state;
    state_t next_state;
    logic   auto_pend;
    logic   req_phase;
    logic   wait_phase;
    logic   accept;
    logic   capture;
    logic   match;
    logic   expired;
    logic   start_check;

    assign req_phase   = (state == ID_REQ) || (state == TS_REQ);
    assign wait_phase  = (state == ID_WAIT) || (state == TS_WAIT);
    assign busy        = req_phase || wait_phase;
    assign done        = (state == DONE);
    assign address     = (state == TS_REQ);
    assign start_check = ((state == IDLE) || (state == DONE)) && (start || auto_pend);

    montre_de1_avm_read_ctl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read_ctl (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_phase    (req_phase),
        .wait_phase   (wait_phase),
        .waitrequest  (waitrequest),
        .readdatavalid(readdatavalid),
        .readdata     (readdata),
        .expected     ((state == TS_WAIT) ? EXPECTED_TS : EXPECTED_ID),
        .read         (read),
        .accept       (accept),
        .capture      (capture),
        .match        (match),
        .expired      (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start_check) next_state = ID_REQ;
            ID_REQ:     if (accept) next_state = ID_WAIT; else if (expired) next_state = DONE;
            ID_WAIT:    if (capture) next_state = TS_REQ; else if (expired) next_state = DONE;
            TS_REQ:     if (accept) next_state = TS_WAIT; else if (expired) next_state = DONE;
            TS_WAIT:    if (capture || expired) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            auto_pend <= (AUTO_START != 0);
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state     <= next_state;
            auto_pend <= 1'b0;
            if (start_check) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture && state == ID_WAIT) begin
                id_value <= readdata;
                id_ok    <= match;
            end
            if (capture && state == TS_WAIT) begin
                ts_value <= readdata;
                ts_ok    <= match;
            end
            if (expired) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/montre_de1_sysid_checker.md
MONTRE_DE1_SYSID_CHECKER -- requirements
Module: montre_de1_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, 32-bit system ID expected at word address 0.
REQ-002 Parameter EXPECTED_TS, default 1684023273, 32-bit timestamp expected at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles allowed per read transaction (1..65535).
REQ-004 Parameter AUTO_START, default 1; if 1, a check starts on the first cycle after reset is released.
REQ-005 clock  input  1  single system clock; all logic rising-edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  single-cycle pulse; begins a check when idle or done.
REQ-008 address  output  1  Avalon-MM master word address.
REQ-009 read  output  1  Avalon-MM read request.
REQ-010 waitrequest  input  1  slave stall; request is held while it is high.
REQ-011 readdata  input  32  slave read data.
REQ-012 readdatavalid  input  1  readdata qualifier; variable latency of 0 or more cycles after acceptance.
REQ-013 busy  output  1  high while a check is in progress.
REQ-014 done  output  1  sticky; high once a check has completed or timed out.
REQ-015 id_ok, ts_ok  output  1 each  comparison results, valid while done is high.
REQ-016 timeout  output  1  sticky; high if any transaction exceeded TIMEOUT_CYCLES.
REQ-017 id_value, ts_value  output  32 each  captured readdata for address 0 and address 1.

Function
REQ-018 FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
REQ-019 IDLE/DONE + start (or first post-reset cycle when AUTO_START=1) -> ID_REQ; in the same transition, done, id_ok, ts_ok and timeout clear and the timeout counter loads 0.
REQ-020 ID_REQ: read=1, address=0; read and address are held stable while waitrequest=1; read&!waitrequest -> ID_WAIT.
REQ-021 ID_WAIT: read=0; readdatavalid -> id_value<=readdata, id_ok<=(readdata==EXPECTED_ID), then -> TS_REQ.
REQ-022 TS_REQ/TS_WAIT mirror ID_REQ/ID_WAIT with address=1; the capture goes to ts_value and ts_ok, then -> DONE with done=1.
REQ-023 A readdatavalid in the same cycle as acceptance is captured in ID_WAIT/TS_WAIT only; readdatavalid outside *_WAIT is ignored.
REQ-024 The timeout counter is 16-bit, cleared on every REQ->WAIT and WAIT->REQ/DONE transition, and increments in every other REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> DONE with timeout=1, read=0, and comparisons of unfinished reads left at 0.
REQ-025 start while busy is ignored.
REQ-026 busy = state not in {IDLE, DONE}; exactly one read is outstanding at any time.
REQ-027 Minimum check latency with waitrequest=0 and readdatavalid one cycle after acceptance: done rises 5 cycles after the cycle in which start is sampled.

Reset
REQ-028 When reset_n=0 at a clock edge: state<=IDLE; read=0, address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, and counter=0.
REQ-029 Reset asserted mid-transaction aborts it immediately, and a late readdatavalid after reset is ignored.

Structure
REQ-030 A shared package montre_de1_sysid_pkg holds the state enumeration, the default ID and timestamp constants, and the counter width.
REQ-031 One sub-module, montre_de1_avm_read_ctl, implements the single-read handshake (request hold, acceptance, data capture, timeout); the top level sequences it twice.

Verification
REQ-032 Bench drives the system-ID slave model with address 1 returning 1684023273 and address 0 returning 0, waitrequest=0 and immediate data -> done=1, id_ok=1, ts_ok=1, timeout=0, and ts_value=1684023273.
REQ-033 Slave returns 0xDEADBEEF at address 1 -> done=1, id_ok=1, ts_ok=0, and ts_value=0xDEADBEEF.
REQ-034 waitrequest held for 7 cycles on each request -> read and address are stable throughout, and the check passes.
REQ-035 TIMEOUT_CYCLES=10 and readdatavalid never asserted on address 0 -> after 10 cycles in ID_WAIT: done=1, timeout=1, id_ok=0, ts_ok=0, and no address-1 read is issued.
REQ-036 reset_n pulled low during TS_WAIT, followed by a readdatavalid -> all outputs return to reset values and remain there with AUTO_START=0.
REQ-037 start pulsed during busy and again in DONE -> the first pulse is ignored, and the second clears done and reruns the check.
